alu_exec_unit: RTL and testbench



---
 rtl/alu_exec_unit_pkg.sv | 53 +++++
 rtl/alu_exec_unit_if.sv | 32 +++
 rtl/alu_exec_unit_compute.sv | 81 ++++++++
 rtl/alu_exec_unit.sv | 113 +++++++++++
 tb/tb_alu_exec_unit.sv | 366 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_exec_unit_pkg.sv
// alu_exec_unit_pkg: shared definitions for the integer execution unit.
//   op_e            RV32I operation codes carried on the dispatch op field
//   ENTRY_W_DEF     default ROB tag width
//   ENTRY_NULL      null ROB tag, TRUE/FALSE single-bit constants
//   uses_imm()      selects the immediate as second operand
package alu_exec_unit_pkg;

  localparam int unsigned ENTRY_W_DEF = 6;
  localparam logic [ENTRY_W_DEF-1:0] ENTRY_NULL = '0;
  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [5:0] {
    OP_LUI   = 6'd1,
    OP_AUIPC = 6'd2,
    OP_JAL   = 6'd3,
    OP_JALR  = 6'd4,
    OP_BEQ   = 6'd5,
    OP_BNE   = 6'd6,
    OP_BLT   = 6'd7,
    OP_BGE   = 6'd8,
    OP_BLTU  = 6'd9,
    OP_BGEU  = 6'd10,
    // 11..18 are loads/stores, handled by the LSB
    OP_ADDI  = 6'd19,
    OP_SLTI  = 6'd20,
    OP_SLTIU = 6'd21,
    OP_XORI  = 6'd22,
    OP_ORI   = 6'd23,
    OP_ANDI  = 6'd24,
    OP_SLLI  = 6'd25,
    OP_SRLI  = 6'd26,
    OP_SRAI  = 6'd27,
    OP_ADD   = 6'd28,
    OP_SUB   = 6'd29,
    OP_SLL   = 6'd30,
    OP_SLT   = 6'd31,
    OP_SLTU  = 6'd32,
    OP_XOR   = 6'd33,
    OP_SRL   = 6'd34,
    OP_SRA   = 6'd35,
    OP_OR    = 6'd36,
    OP_AND   = 6'd37
  } op_e;

  // Immediate is the second operand for I-type, LUI, AUIPC, JAL and JALR;
  // R-type and branches compare/combine against rs2.
  function automatic logic uses_imm(input logic [5:0] op);
    return (op >= 6'(OP_LUI)  && op <= 6'(OP_JALR)) ||
           (op >= 6'(OP_ADDI) && op <= 6'(OP_SRAI));
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: dispatch request from the reservation station plus the
// ALU common-data-bus broadcast back to RS/LSB/ROB.
//   master : reservation-station side (drives dispatch, observes CDB)
//   slave  : execution-unit side (consumes dispatch, drives CDB)
interface alu_exec_unit_if #(
  parameter int unsigned ENTRY_W = 6,
  parameter int unsigned XLEN    = 32
);
  logic               new_calculate;
  logic [5:0]         op_in;
  logic [XLEN-1:0]    vj_in;
  logic [XLEN-1:0]    vk_in;
  logic [XLEN-1:0]    imm_in;
  logic [XLEN-1:0]    pc_in;
  logic [ENTRY_W-1:0] entry_in;

  logic               alu_broadcast;
  logic [ENTRY_W-1:0] alu_entry;
  logic [XLEN-1:0]    alu_value;
  logic [XLEN-1:0]    alu_pc_out;
  logic               alu_jump;

  modport master (
    output new_calculate, op_in, vj_in, vk_in, imm_in, pc_in, entry_in,
    input  alu_broadcast, alu_entry, alu_value, alu_pc_out, alu_jump
  );

  modport slave (
    input  new_calculate, op_in, vj_in, vk_in, imm_in, pc_in, entry_in,
    output alu_broadcast, alu_entry, alu_value, alu_pc_out, alu_jump
  );
endinterface

// File: rtl/alu_exec_unit_compute.sv
// alu_compute: combinational result/next-PC evaluation from the S1 registers.
//   op        operation code
//   vj, opb   first operand and preselected second operand (imm or rs2)
//   pc4       pc+4, pcimm pc+imm, jalr_tgt (vj+imm)&~1
//   value     writeback value, pc_out resolved next PC
//   jump      control transfer taken, handled op belongs to this unit
module alu_compute
  import alu_exec_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [5:0]      op,
  input  logic [XLEN-1:0] vj,
  input  logic [XLEN-1:0] opb,
  input  logic [XLEN-1:0] pc4,
  input  logic [XLEN-1:0] pcimm,
  input  logic [XLEN-1:0] jalr_tgt,
  output logic [XLEN-1:0] value,
  output logic [XLEN-1:0] pc_out,
  output logic            jump,
  output logic            handled
);

  logic [4:0] shamt;
  logic       lt_s;
  logic       lt_u;
  logic       eq;

  assign shamt = opb[4:0];
  assign lt_s  = $signed(vj) < $signed(opb);
  assign lt_u  = vj < opb;
  assign eq    = vj == opb;

  always_comb begin
    logic taken;
    taken   = 1'b0;
    value   = '0;
    pc_out  = pc4;
    jump    = 1'b0;
    handled = 1'b1;
    case (op)
      OP_LUI:              value = opb;
      OP_AUIPC:            value = pcimm;
      OP_JAL: begin
        value  = pc4;
        pc_out = pcimm;
        jump   = 1'b1;
      end
      OP_JALR: begin
        value  = pc4;
        pc_out = jalr_tgt;
        jump   = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        case (op)
          OP_BEQ:  taken = eq;
          OP_BNE:  taken = !eq;
          OP_BLT:  taken = lt_s;
          OP_BGE:  taken = !lt_s;
          OP_BLTU: taken = lt_u;
          default: taken = !lt_u;
        endcase
        value  = {{(XLEN-1){1'b0}}, taken};
        pc_out = taken ? pcimm : pc4;
        jump   = taken;
      end
      OP_ADDI, OP_ADD:     value = vj + opb;
      OP_SUB:              value = vj - opb;
      OP_SLTI, OP_SLT:     value = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLTIU, OP_SLTU:   value = {{(XLEN-1){1'b0}}, lt_u};
      OP_XORI, OP_XOR:     value = vj ^ opb;
      OP_ORI, OP_OR:       value = vj | opb;
      OP_ANDI, OP_AND:     value = vj & opb;
      OP_SLLI, OP_SLL:     value = vj << shamt;
      OP_SRLI, OP_SRL:     value = vj >> shamt;
      OP_SRAI, OP_SRA:     value = XLEN'($signed(vj) >>> shamt);
      default:             handled = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: 2-stage RV32I ALU/branch/jump execution unit.
//   clk_in     clock
//   rst_in     synchronous active-high reset
//   rdy_in     global ready, low holds every register
//   roll_back  misprediction flush
//   bus        dispatch in / CDB broadcast out (alu_exec_unit_if.slave)
// S1 latches the dispatched op with operands preselected; S2 registers the
// alu_compute result onto the CDB.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int unsigned ENTRY_W = 6,
  parameter int unsigned XLEN    = 32
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  input  logic          roll_back,
  alu_exec_unit_if.slave bus
);

  logic               s1_valid;
  logic [5:0]         s1_op;
  logic [ENTRY_W-1:0] s1_entry;
  logic [XLEN-1:0]    s1_vj;
  logic [XLEN-1:0]    s1_opb;
  logic [XLEN-1:0]    s1_pc4;
  logic [XLEN-1:0]    s1_pcimm;
  logic [XLEN-1:0]    s1_jalr_tgt;

  logic [XLEN-1:0]    c_value;
  logic [XLEN-1:0]    c_pc_out;
  logic               c_jump;
  logic               c_handled;

  logic               broadcast_q;
  logic [ENTRY_W-1:0] entry_q;
  logic [XLEN-1:0]    value_q;
  logic [XLEN-1:0]    pc_out_q;
  logic               jump_q;

  logic [XLEN-1:0]    jalr_sum;
  assign jalr_sum = bus.vj_in + bus.imm_in;

  // Stage 1: operand preselection and address precompute.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_valid    <= 1'b0;
      s1_op       <= '0;
      s1_entry    <= '0;
      s1_vj       <= '0;
      s1_opb      <= '0;
      s1_pc4      <= '0;
      s1_pcimm    <= '0;
      s1_jalr_tgt <= '0;
    end else if (roll_back) begin
      s1_valid <= 1'b0;
    end else if (rdy_in) begin
      s1_valid <= bus.new_calculate;
      if (bus.new_calculate) begin
        s1_op       <= bus.op_in;
        s1_entry    <= bus.entry_in;
        s1_vj       <= bus.vj_in;
        s1_opb      <= uses_imm(bus.op_in) ? bus.imm_in : bus.vk_in;
        s1_pc4      <= bus.pc_in + XLEN'(4);
        s1_pcimm    <= bus.pc_in + bus.imm_in;
        s1_jalr_tgt <= {jalr_sum[XLEN-1:1], 1'b0};
      end
    end
  end

  alu_compute #(.XLEN(XLEN)) u_compute (
    .op       (s1_op),
    .vj       (s1_vj),
    .opb      (s1_opb),
    .pc4      (s1_pc4),
    .pcimm    (s1_pcimm),
    .jalr_tgt (s1_jalr_tgt),
    .value    (c_value),
    .pc_out   (c_pc_out),
    .jump     (c_jump),
    .handled  (c_handled)
  );

  // Stage 2: CDB registers. Data only moves on a real broadcast so the bus
  // keeps showing the last result between pulses.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      broadcast_q <= 1'b0;
      entry_q     <= '0;
      value_q     <= '0;
      pc_out_q    <= '0;
      jump_q      <= 1'b0;
    end else if (roll_back) begin
      broadcast_q <= 1'b0;
    end else if (rdy_in) begin
      broadcast_q <= s1_valid & c_handled;
      if (s1_valid & c_handled) begin
        entry_q  <= s1_entry;
        value_q  <= c_value;
        pc_out_q <= c_pc_out;
        jump_q   <= c_jump;
      end
    end
  end

  assign bus.alu_broadcast = broadcast_q;
  assign bus.alu_entry     = entry_q;
  assign bus.alu_value     = value_q;
  assign bus.alu_pc_out    = pc_out_q;
  assign bus.alu_jump      = jump_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed self-checking bench for alu_exec_unit.
module tb_alu_exec_unit;
  import alu_exec_unit_pkg::*;

  logic clk_in;
  logic rst_in;
  logic rdy_in;
  logic roll_back;

  int checks;
  int errors;

  alu_exec_unit_if #(.ENTRY_W(6), .XLEN(32)) bus ();

  alu_exec_unit #(.ENTRY_W(6), .XLEN(32)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .roll_back (roll_back),
    .bus       (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic dispatch(input logic [5:0] op, input logic [31:0] vj,
                          input logic [31:0] vk, input logic [31:0] imm,
                          input logic [31:0] pc, input logic [5:0] entry);
    bus.new_calculate = 1'b1;
    bus.op_in         = op;
    bus.vj_in         = vj;
    bus.vk_in         = vk;
    bus.imm_in        = imm;
    bus.pc_in         = pc;
    bus.entry_in      = entry;
  endtask

  task automatic idle();
    bus.new_calculate = 1'b0;
  endtask

  // Dispatch one op and advance until its broadcast cycle.
  task automatic run_one(input logic [5:0] op, input logic [31:0] vj,
                         input logic [31:0] vk, input logic [31:0] imm,
                         input logic [31:0] pc, input logic [5:0] entry);
    dispatch(op, vj, vk, imm, pc, entry);
    step();
    idle();
    step();
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    step();
    step();
    checks++;
    if (bus.alu_broadcast !== 1'b0 || bus.alu_entry !== 6'd0 || bus.alu_value !== 32'd0 ||
        bus.alu_pc_out !== 32'd0 || bus.alu_jump !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: bc=%b entry=%0d value=%h pc=%h jump=%b, expected all zero",
               bus.alu_broadcast, bus.alu_entry, bus.alu_value, bus.alu_pc_out, bus.alu_jump);
    end
    rst_in = 1'b0;
    step();
    checks++;
    if (bus.alu_broadcast !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_bc: got %b expected 0", bus.alu_broadcast);
    end
  endtask

  task automatic test_add();
    dispatch(OP_ADD, 32'hFFFF_FFFF, 32'd2, 32'h33, 32'h200, 6'd5);
    step();
    idle();
    checks++;
    if (bus.alu_broadcast !== 1'b0) begin
      errors++;
      $display("FAIL add_early_bc: got %b expected 0", bus.alu_broadcast);
    end
    step();
    checks++;
    if (bus.alu_broadcast !== 1'b1 || bus.alu_entry !== 6'd5 || bus.alu_value !== 32'd1 ||
        bus.alu_pc_out !== 32'h204 || bus.alu_jump !== 1'b0) begin
      errors++;
      $display("FAIL add_result: bc=%b entry=%0d value=%h pc=%h jump=%b, expected 1 5 00000001 00000204 0",
               bus.alu_broadcast, bus.alu_entry, bus.alu_value, bus.alu_pc_out, bus.alu_jump);
    end
    step();
    checks++;
    if (bus.alu_broadcast !== 1'b0 || bus.alu_value !== 32'd1 || bus.alu_entry !== 6'd5) begin
      errors++;
      $display("FAIL add_after: bc=%b value=%h entry=%0d, expected 0 00000001 5",
               bus.alu_broadcast, bus.alu_value, bus.alu_entry);
    end
  endtask

  task automatic test_branch();
    run_one(OP_BLT, 32'hFFFF_FFFE, 32'd1, 32'h20, 32'h100, 6'd6);
    checks++;
    if (bus.alu_broadcast !== 1'b1 || bus.alu_value !== 32'd1 ||
        bus.alu_pc_out !== 32'h120 || bus.alu_jump !== 1'b1) begin
      errors++;
      $display("FAIL blt: bc=%b value=%h pc=%h jump=%b, expected 1 00000001 00000120 1",
               bus.alu_broadcast, bus.alu_value, bus.alu_pc_out, bus.alu_jump);
    end
    run_one(OP_BLTU, 32'hFFFF_FFFE, 32'd1, 32'h20, 32'h100, 6'd7);
    checks++;
    if (bus.alu_broadcast !== 1'b1 || bus.alu_value !== 32'd0 ||
        bus.alu_pc_out !== 32'h104 || bus.alu_jump !== 1'b0) begin
      errors++;
      $display("FAIL bltu: bc=%b value=%h pc=%h jump=%b, expected 1 00000000 00000104 0",
               bus.alu_broadcast, bus.alu_value, bus.alu_pc_out, bus.alu_jump);
    end
    run_one(OP_BNE, 32'd4, 32'd4, 32'h40, 32'h300, 6'd8);
    checks++;
    if (bus.alu_value !== 32'd0 || bus.alu_pc_out !== 32'h304 || bus.alu_jump !== 1'b0) begin
      errors++;
      $display("FAIL bne_equal: value=%h pc=%h jump=%b, expected 00000000 00000304 0",
               bus.alu_value, bus.alu_pc_out, bus.alu_jump);
    end
    run_one(OP_BGEU, 32'h8000_0000, 32'd1, 32'hFFFF_FFF0, 32'h300, 6'd9);
    checks++;
    if (bus.alu_value !== 32'd1 || bus.alu_pc_out !== 32'h2F0 || bus.alu_jump !== 1'b1) begin
      errors++;
      $display("FAIL bgeu_back: value=%h pc=%h jump=%b, expected 00000001 000002f0 1",
               bus.alu_value, bus.alu_pc_out, bus.alu_jump);
    end
  endtask

  task automatic test_jump_shift();
    run_one(OP_JALR, 32'h1001, 32'hDEAD, 32'd2, 32'h40, 6'd10);
    checks++;
    if (bus.alu_pc_out !== 32'h1002 || bus.alu_value !== 32'h44 || bus.alu_jump !== 1'b1) begin
      errors++;
      $display("FAIL jalr: pc=%h value=%h jump=%b, expected 00001002 00000044 1",
               bus.alu_pc_out, bus.alu_value, bus.alu_jump);
    end
    run_one(OP_JAL, 32'd0, 32'd0, 32'h100, 32'h40, 6'd11);
    checks++;
    if (bus.alu_pc_out !== 32'h140 || bus.alu_value !== 32'h44 || bus.alu_jump !== 1'b1) begin
      errors++;
      $display("FAIL jal: pc=%h value=%h jump=%b, expected 00000140 00000044 1",
               bus.alu_pc_out, bus.alu_value, bus.alu_jump);
    end
    run_one(OP_SRAI, 32'h8000_0000, 32'd0, 32'd4, 32'h0, 6'd12);
    checks++;
    if (bus.alu_value !== 32'hF800_0000) begin
      errors++;
      $display("FAIL srai: got %h expected f8000000", bus.alu_value);
    end
    run_one(OP_SRL, 32'h8000_0000, 32'h24, 32'd0, 32'h0, 6'd13);
    checks++;
    if (bus.alu_value !== 32'h0800_0000) begin
      errors++;
      $display("FAIL srl_shamt5: got %h expected 08000000", bus.alu_value);
    end
    run_one(OP_SLTIU, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'h0, 6'd14);
    checks++;
    if (bus.alu_value !== 32'd1) begin
      errors++;
      $display("FAIL sltiu: got %h expected 00000001", bus.alu_value);
    end
    run_one(OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h0, 6'd15);
    checks++;
    if (bus.alu_value !== 32'd1) begin
      errors++;
      $display("FAIL slt: got %h expected 00000001", bus.alu_value);
    end
    run_one(OP_AUIPC, 32'd0, 32'd0, 32'h1234_5000, 32'h10, 6'd16);
    checks++;
    if (bus.alu_value !== 32'h1234_5010 || bus.alu_pc_out !== 32'h14 || bus.alu_jump !== 1'b0) begin
      errors++;
      $display("FAIL auipc: value=%h pc=%h jump=%b, expected 12345010 00000014 0",
               bus.alu_value, bus.alu_pc_out, bus.alu_jump);
    end
  endtask

  task automatic test_back_to_back();
    dispatch(OP_ADDI, 32'd10, 32'd99, 32'd5, 32'h0, 6'd1);
    step();
    dispatch(OP_SUB, 32'd10, 32'd3, 32'd77, 32'h4, 6'd2);
    step();
    checks++;
    if (bus.alu_broadcast !== 1'b1 || bus.alu_entry !== 6'd1 || bus.alu_value !== 32'd15) begin
      errors++;
      $display("FAIL b2b_addi: bc=%b entry=%0d value=%h, expected 1 1 0000000f",
               bus.alu_broadcast, bus.alu_entry, bus.alu_value);
    end
    dispatch(6'd13, 32'd1, 32'd2, 32'd3, 32'h8, 6'd3);
    step();
    idle();
    checks++;
    if (bus.alu_broadcast !== 1'b1 || bus.alu_entry !== 6'd2 || bus.alu_value !== 32'd7) begin
      errors++;
      $display("FAIL b2b_sub: bc=%b entry=%0d value=%h, expected 1 2 00000007",
               bus.alu_broadcast, bus.alu_entry, bus.alu_value);
    end
    step();
    checks++;
    if (bus.alu_broadcast !== 1'b0 || bus.alu_entry === 6'd3) begin
      errors++;
      $display("FAIL b2b_load: bc=%b entry=%0d, expected bc 0 and entry not 3",
               bus.alu_broadcast, bus.alu_entry);
    end
    step();
    checks++;
    if (bus.alu_broadcast !== 1'b0) begin
      errors++;
      $display("FAIL b2b_tail: got %b expected 0", bus.alu_broadcast);
    end
  endtask

  task automatic test_roll_back();
    dispatch(OP_ADD, 32'd1, 32'd1, 32'd0, 32'h0, 6'd20);
    step();
    idle();
    roll_back = 1'b1;
    step();
    roll_back = 1'b0;
    checks++;
    if (bus.alu_broadcast !== 1'b0) begin
      errors++;
      $display("FAIL rb_inflight: got %b expected 0", bus.alu_broadcast);
    end
    step();
    checks++;
    if (bus.alu_broadcast !== 1'b0) begin
      errors++;
      $display("FAIL rb_inflight_late: got %b expected 0", bus.alu_broadcast);
    end
    dispatch(OP_ADD, 32'd2, 32'd2, 32'd0, 32'h0, 6'd21);
    roll_back = 1'b1;
    step();
    roll_back = 1'b0;
    idle();
    step();
    checks++;
    if (bus.alu_broadcast !== 1'b0) begin
      errors++;
      $display("FAIL rb_coincident: got %b expected 0", bus.alu_broadcast);
    end
    step();
    checks++;
    if (bus.alu_broadcast !== 1'b0) begin
      errors++;
      $display("FAIL rb_coincident_late: got %b expected 0", bus.alu_broadcast);
    end
    // roll_back must win over a stalled pipeline.
    dispatch(OP_ADD, 32'd3, 32'd3, 32'd0, 32'h0, 6'd22);
    step();
    idle();
    rdy_in = 1'b0;
    roll_back = 1'b1;
    step();
    rdy_in = 1'b1;
    roll_back = 1'b0;
    step();
    checks++;
    if (bus.alu_broadcast !== 1'b0) begin
      errors++;
      $display("FAIL rb_while_stalled: got %b expected 0", bus.alu_broadcast);
    end
  endtask

  task automatic test_stall();
    dispatch(OP_ADD, 32'd3, 32'd4, 32'd0, 32'h0, 6'd9);
    step();
    idle();
    rdy_in = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.alu_broadcast !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold_%0d: got %b expected 0", i, bus.alu_broadcast);
      end
    end
    rdy_in = 1'b1;
    step();
    checks++;
    if (bus.alu_broadcast !== 1'b1 || bus.alu_entry !== 6'd9 || bus.alu_value !== 32'd7) begin
      errors++;
      $display("FAIL stall_resume: bc=%b entry=%0d value=%h, expected 1 9 00000007",
               bus.alu_broadcast, bus.alu_entry, bus.alu_value);
    end
    step();
    checks++;
    if (bus.alu_broadcast !== 1'b0) begin
      errors++;
      $display("FAIL stall_pulse: got %b expected 0", bus.alu_broadcast);
    end
    // A broadcast already on the bus is held through a pause, then drops.
    run_one(OP_OR, 32'hF0, 32'h0F, 32'd0, 32'h0, 6'd30);
    rdy_in = 1'b0;
    step();
    checks++;
    if (bus.alu_broadcast !== 1'b1 || bus.alu_value !== 32'hFF) begin
      errors++;
      $display("FAIL stall_bc_held: bc=%b value=%h, expected 1 000000ff",
               bus.alu_broadcast, bus.alu_value);
    end
    rdy_in = 1'b1;
    step();
    checks++;
    if (bus.alu_broadcast !== 1'b0) begin
      errors++;
      $display("FAIL stall_bc_drop: got %b expected 0", bus.alu_broadcast);
    end
  endtask

  task automatic test_mid_reset();
    dispatch(OP_XOR, 32'hFF, 32'h0F, 32'd0, 32'h50, 6'd33);
    step();
    idle();
    rst_in = 1'b1;
    roll_back = 1'b1;
    step();
    rst_in = 1'b0;
    roll_back = 1'b0;
    checks++;
    if (bus.alu_broadcast !== 1'b0 || bus.alu_entry !== 6'd0 || bus.alu_value !== 32'd0 ||
        bus.alu_pc_out !== 32'd0 || bus.alu_jump !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: bc=%b entry=%0d value=%h pc=%h jump=%b, expected all zero",
               bus.alu_broadcast, bus.alu_entry, bus.alu_value, bus.alu_pc_out, bus.alu_jump);
    end
    step();
    checks++;
    if (bus.alu_broadcast !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_late: got %b expected 0", bus.alu_broadcast);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_in = 1'b1;
    rdy_in = 1'b1;
    roll_back = 1'b0;
    bus.new_calculate = 1'b0;
    bus.op_in = '0;
    bus.vj_in = '0;
    bus.vk_in = '0;
    bus.imm_in = '0;
    bus.pc_in = '0;
    bus.entry_in = '0;
    test_reset();
    test_add();
    test_branch();
    test_jump_shift();
    test_back_to_back();
    test_roll_back();
    test_stall();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
